// File: rtl/sd_card_ctrl_if.sv
// Command-generator bus: sd_card_ctrl drives go/cmd/arg/ignore_count (master),
// the SPI command generator answers with done/response (slave).
interface sd_card_ctrl_if;
    logic        go;
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic [7:0]  ignore_count;
    logic        done;
    logic [7:0]  response;
    logic        response_ready;

    modport master (
        output go, cmd, arg, ignore_count,
        input  done, response, response_ready
    );

    modport slave (
        input  go, cmd, arg, ignore_count,
        output done, response, response_ready
    );
endinterface

// File: rtl/sd_card_ctrl.sv
// SD card (SPI mode) sequencer: power-up/init, then single-block CMD17 reads.
// Optional macro SD_CTRL_TIMEOUT_EN bounds the CMD55/ACMD41 loop to ACMD41_RETRIES.
module sd_card_ctrl #(
    parameter int         CMD0_RETRIES   = 8,
`ifdef SD_CTRL_TIMEOUT_EN
    parameter int         ACMD41_RETRIES = 1000,
`endif
    parameter logic [7:0] IGNORE_COUNT   = 8'd0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           init_start,
    input  logic           rd_req,
    input  logic [31:0]    rd_addr,
    output logic           rd_ack,
    output logic           rd_done,
    output logic           card_ready,
    output logic           busy,
    output logic           error,
    output logic [2:0]     err_code,
    output logic           sdhc,
    sd_card_ctrl_if.master gen
);

    localparam logic [4:0] S_IDLE         = 5'd0;
    localparam logic [4:0] S_ISSUE_PULSE  = 5'd1;
    localparam logic [4:0] S_WAIT_PULSE   = 5'd2;
    localparam logic [4:0] S_ISSUE_CMD0   = 5'd3;
    localparam logic [4:0] S_WAIT_CMD0    = 5'd4;
    localparam logic [4:0] S_ISSUE_CMD8   = 5'd5;
    localparam logic [4:0] S_WAIT_CMD8    = 5'd6;
    localparam logic [4:0] S_ISSUE_CMD55  = 5'd7;
    localparam logic [4:0] S_WAIT_CMD55   = 5'd8;
    localparam logic [4:0] S_ISSUE_ACMD41 = 5'd9;
    localparam logic [4:0] S_WAIT_ACMD41  = 5'd10;
    localparam logic [4:0] S_ISSUE_CMD16  = 5'd11;
    localparam logic [4:0] S_WAIT_CMD16   = 5'd12;
    localparam logic [4:0] S_READY        = 5'd13;
    localparam logic [4:0] S_ISSUE_RD     = 5'd14;
    localparam logic [4:0] S_WAIT_RD      = 5'd15;
    localparam logic [4:0] S_ERROR        = 5'd16;

    localparam logic [7:0] CMD0_LAST = 8'(CMD0_RETRIES - 1);
`ifdef SD_CTRL_TIMEOUT_EN
    localparam logic [15:0] ACMD41_LAST = 16'(ACMD41_RETRIES - 1);
    logic [15:0] acmd41_cnt;
`endif

    logic [4:0]  state;
    logic [7:0]  resp_q;
    logic [7:0]  resp_now;
    logic [7:0]  cmd0_cnt;
    logic [31:0] addr_q;
    logic        start_ok;
    logic        issue;
    logic [5:0]  issue_cmd;
    logic [31:0] issue_arg;
    logic [7:0]  issue_ign;
    logic [4:0]  issue_wait;

    // A response arriving in the same cycle as done still counts for the decision.
    assign resp_now   = gen.response_ready ? gen.response : resp_q;
    assign card_ready = (state == S_READY);
    assign error      = (state == S_ERROR);
    assign busy       = !(state == S_IDLE || state == S_READY || state == S_ERROR);
    assign start_ok   = init_start && (state == S_IDLE || state == S_READY || state == S_ERROR);

    always_comb begin
        issue      = 1'b0;
        issue_cmd  = 6'd0;
        issue_arg  = 32'd0;
        issue_ign  = 8'd0;
        issue_wait = state;
        case (state)
            S_ISSUE_PULSE:  begin issue = 1'b1; issue_cmd = 6'h3F; issue_wait = S_WAIT_PULSE; end
            S_ISSUE_CMD0:   begin issue = 1'b1; issue_cmd = 6'd0;  issue_wait = S_WAIT_CMD0; end
            S_ISSUE_CMD8:   begin
                issue = 1'b1; issue_cmd = 6'd8; issue_arg = 32'h0000_01AA; issue_wait = S_WAIT_CMD8;
            end
            S_ISSUE_CMD55:  begin issue = 1'b1; issue_cmd = 6'd55; issue_wait = S_WAIT_CMD55; end
            S_ISSUE_ACMD41: begin
                issue = 1'b1; issue_cmd = 6'd41; issue_wait = S_WAIT_ACMD41;
                issue_arg = sdhc ? 32'h4000_0000 : 32'd0;
            end
            S_ISSUE_CMD16:  begin
                issue = 1'b1; issue_cmd = 6'd16; issue_arg = 32'd512; issue_wait = S_WAIT_CMD16;
            end
            // Standard-capacity cards take a byte address, SDHC a block index.
            S_ISSUE_RD:     begin
                issue = 1'b1; issue_cmd = 6'd17; issue_ign = IGNORE_COUNT; issue_wait = S_WAIT_RD;
                issue_arg = sdhc ? addr_q : {addr_q[22:0], 9'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            rd_ack           <= 1'b0;
            rd_done          <= 1'b0;
            err_code         <= 3'd0;
            sdhc             <= 1'b0;
            cmd0_cnt         <= 8'd0;
            addr_q           <= 32'd0;
            resp_q           <= 8'hFF;
            gen.go           <= 1'b0;
            gen.cmd          <= 6'd0;
            gen.arg          <= 32'd0;
            gen.ignore_count <= 8'd0;
`ifdef SD_CTRL_TIMEOUT_EN
            acmd41_cnt       <= 16'd0;
`endif
        end else begin
            gen.go  <= 1'b0;
            rd_ack  <= 1'b0;
            rd_done <= 1'b0;
            if (gen.response_ready) resp_q <= gen.response;

            // Preloading 8'hFF makes a missing response read as a failure.
            if (issue) begin
                gen.go           <= 1'b1;
                gen.cmd          <= issue_cmd;
                gen.arg          <= issue_arg;
                gen.ignore_count <= issue_ign;
                resp_q           <= 8'hFF;
                state            <= issue_wait;
            end

            if (start_ok) begin
                state    <= S_ISSUE_PULSE;
                err_code <= 3'd0;
                sdhc     <= 1'b0;
                cmd0_cnt <= 8'd0;
`ifdef SD_CTRL_TIMEOUT_EN
                acmd41_cnt <= 16'd0;
`endif
            end else begin
                case (state)
                    S_WAIT_PULSE: if (gen.done) state <= S_ISSUE_CMD0;
                    S_WAIT_CMD0: if (gen.done) begin
                        if (resp_now == 8'h01) begin
                            state <= S_ISSUE_CMD8;
                        end else if (cmd0_cnt == CMD0_LAST) begin
                            state    <= S_ERROR;
                            err_code <= 3'd1;
                        end else begin
                            cmd0_cnt <= cmd0_cnt + 8'd1;
                            state    <= S_ISSUE_CMD0;
                        end
                    end
                    S_WAIT_CMD8: if (gen.done) begin
                        if (resp_now == 8'h01 || resp_now == 8'h05) begin
                            sdhc  <= (resp_now == 8'h01);
                            state <= S_ISSUE_CMD55;
                        end else begin
                            state    <= S_ERROR;
                            err_code <= 3'd2;
                        end
                    end
                    S_WAIT_CMD55: if (gen.done) begin
                        if (resp_now == 8'h00 || resp_now == 8'h01) begin
                            state <= S_ISSUE_ACMD41;
                        end else begin
                            state    <= S_ERROR;
                            err_code <= 3'd3;
                        end
                    end
                    S_WAIT_ACMD41: if (gen.done) begin
                        if (resp_now == 8'h00) begin
                            state <= S_ISSUE_CMD16;
                        end else if (resp_now == 8'h01) begin
`ifdef SD_CTRL_TIMEOUT_EN
                            if (acmd41_cnt == ACMD41_LAST) begin
                                state    <= S_ERROR;
                                err_code <= 3'd3;
                            end else begin
                                acmd41_cnt <= acmd41_cnt + 16'd1;
                                state      <= S_ISSUE_CMD55;
                            end
`else
                            state <= S_ISSUE_CMD55;
`endif
                        end else begin
                            state    <= S_ERROR;
                            err_code <= 3'd3;
                        end
                    end
                    S_WAIT_CMD16: if (gen.done) begin
                        if (resp_now == 8'h00) begin
                            state <= S_READY;
                        end else begin
                            state    <= S_ERROR;
                            err_code <= 3'd4;
                        end
                    end
                    S_READY: if (rd_req) begin
                        rd_ack <= 1'b1;
                        addr_q <= rd_addr;
                        state  <= S_ISSUE_RD;
                    end
                    S_WAIT_RD: if (gen.done) begin
                        rd_done <= 1'b1;
                        if (resp_now == 8'h00) begin
                            state <= S_READY;
                        end else begin
                            state    <= S_ERROR;
                            err_code <= 3'd5;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_card_ctrl.sv
// Bench for sd_card_ctrl: a card/generator model answers each gen.go and a scoreboard
// of expected {cmd, arg, ignore_count} entries is checked as the commands appear.
module tb_sd_card_ctrl;

    localparam logic [7:0] TB_IGN = 8'h03;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_start = 1'b0;
    logic        rd_req = 1'b0;
    logic [31:0] rd_addr = 32'd0;
    logic        rd_ack, rd_done, card_ready, busy, error, sdhc;
    logic [2:0]  err_code;

    sd_card_ctrl_if bus ();

    sd_card_ctrl #(
`ifdef SD_CTRL_TIMEOUT_EN
        .ACMD41_RETRIES(4),
`endif
        .CMD0_RETRIES(8),
        .IGNORE_COUNT(TB_IGN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_start(init_start), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .rd_done(rd_done), .card_ready(card_ready), .busy(busy), .error(error),
        .err_code(err_code), .sdhc(sdhc), .gen(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    typedef logic [45:0] sb_t;
    sb_t sb_q[$];
    sb_t exp_e;
    bit  sb_en = 1'b1;

    logic [7:0] cmd0_resp = 8'h01, cmd8_resp = 8'h01, cmd16_resp = 8'h00, cmd17_resp = 8'h00;
    int  acmd_ones = 0;
    bit  silent16 = 1'b0;

    int         m_cnt = 0, m_acmd_resp = 0;
    logic [5:0] m_cmd = 6'd0;
    int  go_cnt = 0, acmd41_issued = 0, rd_ack_cnt = 0, rd_done_cnt = 0;

    // Card + command generator model; compares every issued command with the scoreboard.
    always @(negedge clk) begin
        bus.response_ready = 1'b0;
        bus.done           = 1'b0;
        bus.response       = 8'h00;
        if (!rst_n) begin
            m_cnt = 0;
        end else begin
            if (rd_ack) rd_ack_cnt++;
            if (rd_done) rd_done_cnt++;
            if (bus.go) begin
                go_cnt++;
                if (bus.cmd == 6'd41) acmd41_issued++;
                if (bus.cmd == 6'h3F) m_acmd_resp = 0;
                if (sb_en) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        $display("[TB] FAIL sb_unexpected_go: got cmd=%0d arg=%h, expected no command", bus.cmd, bus.arg);
                    end else begin
                        exp_e = sb_q.pop_front();
                        if ({bus.cmd, bus.arg, bus.ignore_count} !== exp_e)
                            $display("[TB] FAIL sb_cmd: got cmd=%0d arg=%h ign=%h expected cmd=%0d arg=%h ign=%h",
                                     bus.cmd, bus.arg, bus.ignore_count, exp_e[45:40], exp_e[39:8], exp_e[7:0]);
                        else passes++;
                    end
                end
                m_cmd = bus.cmd;
                m_cnt = 3;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 1 && m_cmd != 6'h3F && !(silent16 && m_cmd == 6'd16)) begin
                    case (m_cmd)
                        6'd0:  bus.response = cmd0_resp;
                        6'd8:  bus.response = cmd8_resp;
                        6'd55: bus.response = 8'h01;
                        6'd41: begin
                            bus.response = (m_acmd_resp < acmd_ones) ? 8'h01 : 8'h00;
                            m_acmd_resp++;
                        end
                        6'd16: bus.response = cmd16_resp;
                        6'd17: bus.response = cmd17_resp;
                        default: bus.response = 8'hFF;
                    endcase
                    bus.response_ready = 1'b1;
                end
                if (m_cnt == 0) bus.done = 1'b1;
            end
        end
    end

    task automatic push(input logic [5:0] c, input logic [31:0] a, input logic [7:0] ign);
        sb_q.push_back({c, a, ign});
    endtask

    task automatic push_init(input bit v2, input int ones);
        push(6'h3F, 32'd0, 8'd0);
        push(6'd0, 32'd0, 8'd0);
        push(6'd8, 32'h0000_01AA, 8'd0);
        for (int i = 0; i <= ones; i++) begin
            push(6'd55, 32'd0, 8'd0);
            push(6'd41, v2 ? 32'h4000_0000 : 32'd0, 8'd0);
        end
        push(6'd16, 32'd512, 8'd0);
    endtask

    task automatic pulse_init();
        @(negedge clk) init_start = 1'b1;
        @(negedge clk) init_start = 1'b0;
    endtask

    task automatic wait_not_busy(input int max_cycles, output bit ok);
        int n = 0;
        repeat (2) @(negedge clk);
        while (busy && n < max_cycles) begin @(negedge clk); n++; end
        ok = !busy;
    endtask

    task automatic wait_rd_done(input int max_cycles, output bit ok);
        int n = 0;
        while (rd_done !== 1'b1 && n < max_cycles) begin @(negedge clk); n++; end
        ok = (rd_done === 1'b1);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if ({rd_ack, rd_done, card_ready, busy, error, sdhc} !== 6'b0)
            $display("[TB] FAIL reset_flags: got %b expected 000000", {rd_ack, rd_done, card_ready, busy, error, sdhc}); else passes++;
        checks++; if (err_code !== 3'd0) $display("[TB] FAIL reset_err_code: got %0d expected 0", err_code); else passes++;
        checks++; if ({bus.go, bus.cmd, bus.arg, bus.ignore_count} !== 47'd0)
            $display("[TB] FAIL reset_gen: got go=%b cmd=%0d arg=%h expected all 0", bus.go, bus.cmd, bus.arg); else passes++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (go_cnt !== 0) $display("[TB] FAIL reset_no_go: got %0d go pulses expected 0", go_cnt); else passes++;
    endtask

    task automatic test_v2_init();
        bit ok;
        int a0 = acmd41_issued;
        cmd0_resp = 8'h01; cmd8_resp = 8'h01; acmd_ones = 2; cmd16_resp = 8'h00;
        push_init(1'b1, 2);
        pulse_init();
        checks++; if (busy !== 1'b1) $display("[TB] FAIL v2_busy: got %b expected 1", busy); else passes++;
        wait_not_busy(3000, ok);
        checks++; if (!ok) $display("[TB] FAIL v2_timeout: got busy=%b expected 0", busy); else passes++;
        checks++; if ({card_ready, sdhc, error} !== 3'b110)
            $display("[TB] FAIL v2_status: got ready/sdhc/error=%b expected 110", {card_ready, sdhc, error}); else passes++;
        checks++; if (acmd41_issued - a0 != 3) $display("[TB] FAIL v2_acmd41_count: got %0d expected 3", acmd41_issued - a0); else passes++;
        checks++; if (sb_q.size() != 0) $display("[TB] FAIL v2_sb_left: got %0d expected 0", sb_q.size()); else passes++;
    endtask

    task automatic test_v1_read();
        bit ok;
        int a0, d0;
        cmd8_resp = 8'h05; acmd_ones = 0; cmd17_resp = 8'h00;
        push_init(1'b0, 0);
        pulse_init();
        checks++; if ({card_ready, busy} !== 2'b01)
            $display("[TB] FAIL v1_reinit_drop: got ready/busy=%b expected 01", {card_ready, busy}); else passes++;
        wait_not_busy(3000, ok);
        checks++; if ({ok, card_ready, sdhc, error} !== 4'b1100)
            $display("[TB] FAIL v1_status: got ok/ready/sdhc/error=%b expected 1100", {ok, card_ready, sdhc, error}); else passes++;
        a0 = rd_ack_cnt; d0 = rd_done_cnt;
        push(6'd17, 32'h0000_0A00, TB_IGN);
        @(negedge clk) begin rd_req = 1'b1; rd_addr = 32'd5; end
        @(negedge clk);
        checks++; if ({rd_ack, bus.go} !== 2'b10) $display("[TB] FAIL v1_ack_latency: got ack/go=%b expected 10", {rd_ack, bus.go}); else passes++;
        rd_req = 1'b0; rd_addr = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if ({rd_ack, bus.go} !== 2'b01) $display("[TB] FAIL v1_go_latency: got ack/go=%b expected 01", {rd_ack, bus.go}); else passes++;
        wait_rd_done(200, ok);
        checks++; if (!ok) $display("[TB] FAIL v1_rd_done_timeout: got rd_done=%b expected 1", rd_done); else passes++;
        repeat (2) @(negedge clk);
        checks++; if (rd_ack_cnt - a0 != 1 || rd_done_cnt - d0 != 1)
            $display("[TB] FAIL v1_pulse_counts: got ack=%0d done=%0d expected 1 1", rd_ack_cnt - a0, rd_done_cnt - d0); else passes++;
        checks++; if ({card_ready, error} !== 2'b10) $display("[TB] FAIL v1_after_read: got ready/error=%b expected 10", {card_ready, error}); else passes++;
        checks++; if (sb_q.size() != 0) $display("[TB] FAIL v1_sb_left: got %0d expected 0", sb_q.size()); else passes++;
    endtask

    task automatic test_cmd0_fail();
        bit ok;
        cmd0_resp = 8'hFF;
        push(6'h3F, 32'd0, 8'd0);
        for (int i = 0; i < 8; i++) push(6'd0, 32'd0, 8'd0);
        pulse_init();
        wait_not_busy(3000, ok);
        checks++; if ({ok, error, card_ready} !== 3'b110)
            $display("[TB] FAIL cmd0_status: got ok/error/ready=%b expected 110", {ok, error, card_ready}); else passes++;
        checks++; if (err_code !== 3'd1) $display("[TB] FAIL cmd0_err_code: got %0d expected 1", err_code); else passes++;
        checks++; if (sb_q.size() != 0) $display("[TB] FAIL cmd0_sb_left: got %0d expected 0", sb_q.size()); else passes++;
        cmd0_resp = 8'h01; cmd8_resp = 8'h01; acmd_ones = 0;
        push_init(1'b1, 0);
        pulse_init();
        checks++; if ({error, busy, err_code} !== 5'b01000)
            $display("[TB] FAIL cmd0_restart: got error/busy/err_code=%b expected 01000", {error, busy, err_code}); else passes++;
        wait_not_busy(3000, ok);
        checks++; if ({ok, card_ready, sdhc} !== 3'b111)
            $display("[TB] FAIL cmd0_recover: got ok/ready/sdhc=%b expected 111", {ok, card_ready, sdhc}); else passes++;
    endtask

    task automatic test_sdhc_read_error();
        bit ok;
        int d0 = rd_done_cnt;
        cmd17_resp = 8'h04;
        push(6'd17, 32'h0001_2345, TB_IGN);
        @(negedge clk) begin rd_req = 1'b1; rd_addr = 32'h0001_2345; end
        @(negedge clk);
        checks++; if (rd_ack !== 1'b1) $display("[TB] FAIL rderr_ack: got %b expected 1", rd_ack); else passes++;
        rd_req = 1'b0;
        wait_rd_done(200, ok);
        checks++; if (!ok) $display("[TB] FAIL rderr_done_timeout: got rd_done=%b expected 1", rd_done); else passes++;
        repeat (2) @(negedge clk);
        checks++; if ({error, card_ready} !== 2'b10) $display("[TB] FAIL rderr_status: got error/ready=%b expected 10", {error, card_ready}); else passes++;
        checks++; if (err_code !== 3'd5) $display("[TB] FAIL rderr_err_code: got %0d expected 5", err_code); else passes++;
        checks++; if (rd_done_cnt - d0 != 1) $display("[TB] FAIL rderr_done_count: got %0d expected 1", rd_done_cnt - d0); else passes++;
        checks++; if (sb_q.size() != 0) $display("[TB] FAIL rderr_sb_left: got %0d expected 0", sb_q.size()); else passes++;
        cmd17_resp = 8'h00;
    endtask

    task automatic test_missing_response();
        bit ok;
        silent16 = 1'b1;
        push_init(1'b1, 0);
        pulse_init();
        wait_not_busy(3000, ok);
        checks++; if ({ok, error, err_code} !== 5'b11100)
            $display("[TB] FAIL noresp_status: got ok/error/err_code=%b expected 11100", {ok, error, err_code}); else passes++;
        checks++; if (sb_q.size() != 0) $display("[TB] FAIL noresp_sb_left: got %0d expected 0", sb_q.size()); else passes++;
        silent16 = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int a0, n;
        acmd_ones = 0;
        push_init(1'b1, 0);
        pulse_init();
        wait_not_busy(3000, ok);
        checks++; if ({ok, card_ready} !== 2'b11) $display("[TB] FAIL b2b_ready: got ok/ready=%b expected 11", {ok, card_ready}); else passes++;
        a0 = rd_ack_cnt;
        acmd_ones = 1;
        push_init(1'b1, 1);
        push(6'd17, 32'h0000_0042, TB_IGN);
        @(negedge clk) begin init_start = 1'b1; rd_req = 1'b1; rd_addr = 32'h42; end
        @(negedge clk) init_start = 1'b0;
        checks++; if ({rd_ack, busy, card_ready} !== 3'b010)
            $display("[TB] FAIL b2b_init_wins: got ack/busy/ready=%b expected 010", {rd_ack, busy, card_ready}); else passes++;
        n = 0;
        while (rd_ack !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        checks++; if (rd_ack !== 1'b1) $display("[TB] FAIL b2b_pending_ack: got %b expected 1", rd_ack); else passes++;
        rd_req = 1'b0;
        wait_rd_done(200, ok);
        repeat (2) @(negedge clk);
        checks++; if ({ok, card_ready} !== 2'b11) $display("[TB] FAIL b2b_read_done: got ok/ready=%b expected 11", {ok, card_ready}); else passes++;
        checks++; if (rd_ack_cnt - a0 != 1) $display("[TB] FAIL b2b_ack_count: got %0d expected 1", rd_ack_cnt - a0); else passes++;
        checks++; if (sb_q.size() != 0) $display("[TB] FAIL b2b_sb_left: got %0d expected 0", sb_q.size()); else passes++;
    endtask

    task automatic test_reset_mid_acmd41();
        int hits = 0, n = 0, g0;
        acmd_ones = 100000;
        sb_en = 1'b0;
        pulse_init();
        while (hits < 2 && n < 3000) begin
            @(negedge clk); n++;
            if (bus.go === 1'b1 && bus.cmd === 6'd41) hits++;
        end
        checks++; if (hits != 2 || busy !== 1'b1) $display("[TB] FAIL rst_reach_acmd41: got hits=%0d busy=%b expected 2 1", hits, busy); else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({rd_ack, rd_done, card_ready, busy, error, sdhc, err_code, bus.go, bus.cmd, bus.arg} !== 48'd0)
            $display("[TB] FAIL rst_outputs: got busy=%b go=%b cmd=%0d arg=%h expected all 0", busy, bus.go, bus.cmd, bus.arg); else passes++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        g0 = go_cnt;
        repeat (20) @(negedge clk);
        checks++; if (go_cnt != g0 || busy !== 1'b0) $display("[TB] FAIL rst_no_go: got go=%0d busy=%b expected 0 0", go_cnt - g0, busy); else passes++;
        sb_en = 1'b1;
    endtask

    task automatic test_acmd41_loop();
        int a0 = acmd41_issued;
        acmd_ones = 100000;
        push(6'h3F, 32'd0, 8'd0);
        push(6'd0, 32'd0, 8'd0);
        push(6'd8, 32'h0000_01AA, 8'd0);
`ifdef SD_CTRL_TIMEOUT_EN
        begin
            bit ok;
            for (int i = 0; i < 4; i++) begin push(6'd55, 32'd0, 8'd0); push(6'd41, 32'h4000_0000, 8'd0); end
            pulse_init();
            wait_not_busy(3000, ok);
            checks++; if ({ok, error, err_code} !== 5'b11011)
                $display("[TB] FAIL acmd41_timeout: got ok/error/err_code=%b expected 11011", {ok, error, err_code}); else passes++;
            checks++; if (acmd41_issued - a0 != 4) $display("[TB] FAIL acmd41_issues: got %0d expected 4", acmd41_issued - a0); else passes++;
        end
`else
        begin
            int n = 0;
            for (int i = 0; i < 100; i++) begin push(6'd55, 32'd0, 8'd0); push(6'd41, 32'h4000_0000, 8'd0); end
            pulse_init();
            while (sb_q.size() != 0 && n < 5000) begin @(negedge clk); n++; end
            sb_en = 1'b0;
            repeat (10) @(negedge clk);
            checks++; if ({busy, error} !== 2'b10) $display("[TB] FAIL acmd41_looping: got busy/error=%b expected 10", {busy, error}); else passes++;
            checks++; if (acmd41_issued - a0 < 100) $display("[TB] FAIL acmd41_issues: got %0d expected at least 100", acmd41_issued - a0); else passes++;
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            sb_en = 1'b1;
        end
`endif
        checks++; if (sb_q.size() != 0) $display("[TB] FAIL acmd41_sb_left: got %0d expected 0", sb_q.size()); else passes++;
    endtask

    initial begin
        test_reset();
        test_v2_init();
        test_v1_read();
        test_cmd0_fail();
        test_sdhc_read_error();
        test_missing_response();
        test_back_to_back();
        test_reset_mid_acmd41();
        test_acmd41_loop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
